isr_stream: RTL and testbench
=============================

// Module: isr_stream
// PURPOSE
//  Parametrised integer square root engine: returns floor(sqrt(value)), the largest
//  r with r*r <= value, for an IN_W-bit unsigned input.
//  Adds a valid/ready handshake on input and output; reset no longer starts a job.
//  Builds the root MSB-first, one bit per trial, squaring each candidate in a
//  pipelined multiplier with MUL_LAT stages. Sits beside the multiply unit as a
//  multi-cycle execution resource.
// PARAMETERS
//  IN_W     64  radicand width; must be even and >= 2
//  MUL_LAT  8   multiplier pipeline depth in cycles; must be >= 1
//  OUT_W    IN_W/2 (localparam)  root width
// PORTS
//  clock      in   1      single clock; all state updates on posedge
//  reset      in   1      synchronous, active-high
//  in_valid   in   1      radicand offered
//  in_ready   out  1      engine can accept a radicand
//  value      in   IN_W   radicand, unsigned
//  out_valid  out  1      result available
//  out_ready  in   1      consumer takes result
//  result     out  OUT_W  floor(sqrt(value))
//  exact      out  1      1 when result*result == value
// BEHAVIOUR
//  - Reset (sync, active-high): state=IDLE, in_ready=1, out_valid=0, result=0, exact=0.
//    Reset overrides every state; an in-flight job is discarded without output.
//    Multiplier pipeline contents are flushed or ignored.
//  - States: IDLE, SQUARE, WAIT, CHECK, DONE. The enum lives in the package.
//  - IDLE: in_ready=1. When in_valid&&in_ready: latch value_q=value, root_q=0,
//    bit_idx=OUT_W-1, go to SQUARE.
//  - SQUARE (1 cycle): cand = root_q | (1<<bit_idx). Pulse mult start with
//    mcand=mplier=cand. Go to WAIT.
//  - WAIT (MUL_LAT cycles): count down; leave when the multiplier's done asserts.
//  - CHECK (1 cycle): if product (2*OUT_W bits, zero-extended) <= value_q, then
//    root_q=cand. Set eq_q=(product==value_q) when the bit is kept.
//    If bit_idx==0 go to DONE; else bit_idx-- and go to SQUARE.
//  - DONE: out_valid=1; result=root_q and exact=eq_q, both held stable while
//    out_valid && !out_ready. On out_ready, go to IDLE. in_ready=0 in every state
//    except IDLE; no new job is accepted in the cycle of the result handshake.
//  - Latency: out_valid rises OUT_W*(MUL_LAT+2)+1 cycles after the accept edge.
//    Default: 321 cycles (requirement < 600).
//  - Arithmetic: cand and root_q are OUT_W wide; product is IN_W wide and never
//    overflows. Compare is unsigned.
//  - Boundaries: value=0 gives 0/exact=1. value=2^IN_W-1 gives all-ones root,
//    exact=0. in_valid during a busy job is ignored, no error.
//    out_ready low stalls indefinitely with outputs stable.
//    in_valid and reset asserted together: reset wins, nothing is latched.
// STRUCTURE
//  - isr_pkg holds: fsm state enum isr_state_t; function isr_latency(IN_W,MUL_LAT).
//  - Sub-module isr_square_pipe: MUL_LAT-stage pipelined squarer
//    (start/done, operand OUT_W, product IN_W). Synchronous reset clears the valid
//    pipeline. Instantiated once; the FSM, counters and compare stay in isr_stream.
// TESTING
//  1. value=16 -> result=4, exact=1, out_valid exactly 321 cycles after accept (defaults).
//  2. value=15 -> 3, exact=0. value=0 -> 0, exact=1. value=1 -> 1, exact=1.
//  3. value=64'hFFFF_FFFF_FFFF_FFFF -> 32'hFFFF_FFFF, exact=0.
//     value=64'hFFFF_FFFE_0000_0001 -> 32'hFFFF_FFFF, exact=1.
//  4. Hold out_ready=0 for 50 cycles after DONE -> result/exact stable,
//     in_ready=0, a second in_valid is ignored.
//  5. Reset asserted at cycle 100 of a job -> next cycle out_valid=0, in_ready=1.
//     A fresh job (value=81) then returns 9 with no stale data.
//  6. IN_W=16, MUL_LAT=3: 500 random radicands vs reference floor-sqrt model;
//     latency = 8*5+1 = 41 each.

Source files
------------

// File: rtl/isr_pkg.sv
// Shared types for the integer square root engine.
// Holds the FSM state enum and a latency helper.
package isr_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SQUARE,
    WAIT,
    CHECK,
    DONE
  } isr_state_t;

  function automatic int isr_latency(input int in_w, input int mul_lat);
    return (in_w / 2) * (mul_lat + 2) + 1;
  endfunction

endpackage

// File: rtl/isr_square_pipe.sv
// Pipelined squarer: product = operand * operand after MUL_LAT cycles.
// Only the valid chain is reset; data stages follow it.
module isr_square_pipe #(
  parameter int OP_W    = 32,
  parameter int MUL_LAT = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [OP_W-1:0]   operand,
  output logic              done,
  output logic [2*OP_W-1:0] product
);

  localparam int P_W = 2 * OP_W;

  logic [MUL_LAT-1:0] vld_q;
  logic [P_W-1:0]     prod_q [MUL_LAT];

  always_ff @(posedge clock) begin
    if (reset) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= start;
      for (int i = 1; i < MUL_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
      end
    end
  end

  always_ff @(posedge clock) begin
    prod_q[0] <= P_W'(operand) * P_W'(operand);
    for (int i = 1; i < MUL_LAT; i++) begin
      prod_q[i] <= prod_q[i-1];
    end
  end

  assign done    = vld_q[MUL_LAT-1];
  assign product = prod_q[MUL_LAT-1];

endmodule

// File: rtl/isr_stream.sv
// Integer square root with valid/ready handshakes.
// Builds the root MSB-first, squaring each candidate in a pipelined squarer.
module isr_stream
  import isr_pkg::*;
#(
  parameter int IN_W    = 64,
  parameter int MUL_LAT = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   value,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IN_W/2-1:0] result,
  output logic              exact
);

  localparam int OUT_W = IN_W / 2;
  localparam int BW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int CW    = $clog2(MUL_LAT + 1);

  isr_state_t       state_q, state_d;
  logic [IN_W-1:0]  value_q;
  logic [OUT_W-1:0] root_q;
  logic [BW-1:0]    bit_idx;
  logic [CW-1:0]    wait_cnt;
  logic             eq_q;
  logic             out_valid_q;
  logic [OUT_W-1:0] result_q;
  logic             exact_q;

  logic [OUT_W-1:0] cand;
  logic             mul_start;
  logic             mul_done;
  logic [IN_W-1:0]  product;
  logic             keep;

  assign cand = root_q | (OUT_W'(1) << bit_idx);
  assign keep = (product <= value_q);

  isr_square_pipe #(
    .OP_W    (OUT_W),
    .MUL_LAT (MUL_LAT)
  ) u_sq (
    .clock   (clock),
    .reset   (reset),
    .start   (mul_start),
    .operand (cand),
    .done    (mul_done),
    .product (product)
  );

  always_comb begin
    state_d   = state_q;
    mul_start = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) state_d = SQUARE;
      end
      SQUARE: begin
        mul_start = 1'b1;
        state_d   = WAIT;
      end
      WAIT: begin
        if (mul_done && wait_cnt == '0) state_d = CHECK;
      end
      CHECK: begin
        state_d = (bit_idx == '0) ? DONE : SQUARE;
      end
      DONE: begin
        if (out_valid_q && out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      value_q     <= '0;
      root_q      <= '0;
      bit_idx     <= '0;
      wait_cnt    <= '0;
      eq_q        <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      exact_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            value_q <= value;
            root_q  <= '0;
            bit_idx <= BW'(OUT_W - 1);
            // A zero radicand keeps no bit, yet its root is exact.
            eq_q    <= (value == '0);
          end
        end
        SQUARE: begin
          wait_cnt <= CW'(MUL_LAT - 1);
        end
        WAIT: begin
          if (wait_cnt != '0) wait_cnt <= wait_cnt - CW'(1);
        end
        CHECK: begin
          if (keep) begin
            root_q <= cand;
            eq_q   <= (product == value_q);
          end
          if (bit_idx != '0) bit_idx <= bit_idx - BW'(1);
        end
        DONE: begin
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
            result_q    <= root_q;
            exact_q     <= eq_q;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign exact     = exact_q;

endmodule

// File: tb/tb_isr_stream.sv
// Bench for isr_stream: default 64-bit engine plus a 16-bit, 3-stage one.
// Results are checked against a floor-sqrt reference model.
module tb_isr_stream;

  localparam int LAT64 = 32 * (8 + 2) + 1;
  localparam int LAT16 = 8 * (3 + 2) + 1;
  localparam int BOUND = 2000;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset;

  logic        iv64, ir64, ov64, or64, ex64;
  logic [63:0] v64;
  logic [31:0] r64;

  logic        iv16, ir16, ov16, or16, ex16;
  logic [15:0] v16;
  logic [7:0]  r16;

  int n_checks = 0;
  int n_fail   = 0;

  isr_stream #(.IN_W(64), .MUL_LAT(8)) dut64 (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (iv64),
    .in_ready  (ir64),
    .value     (v64),
    .out_valid (ov64),
    .out_ready (or64),
    .result    (r64),
    .exact     (ex64)
  );

  isr_stream #(.IN_W(16), .MUL_LAT(3)) dut16 (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (iv16),
    .in_ready  (ir16),
    .value     (v16),
    .out_valid (ov16),
    .out_ready (or16),
    .result    (r16),
    .exact     (ex16)
  );

  function automatic logic [31:0] ref_sqrt64(input logic [63:0] v);
    logic [63:0] lo, hi, mid;
    lo = 64'd0;
    hi = 64'hFFFF_FFFF;
    while (lo < hi) begin
      mid = lo + (hi - lo + 64'd1) / 64'd2;
      if (mid * mid <= v) lo = mid;
      else hi = mid - 64'd1;
    end
    return lo[31:0];
  endfunction

  function automatic int ref_sqrt16(input int v);
    int r;
    r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  task automatic job64(input logic [63:0] v, input logic [31:0] er,
                       input logic ee, input string tag);
    int cyc;
    bit got;
    @(negedge clock);
    iv64 = 1'b1;
    v64  = v;
    n_checks++;
    if (ir64 !== 1'b1) begin
      n_fail++;
      $display("FAIL %s in_ready: got %b want 1", tag, ir64);
    end
    @(posedge clock);
    #1 iv64 = 1'b0;
    cyc = 0;
    got = 0;
    while (!got && cyc < BOUND) begin
      @(posedge clock);
      #1;
      cyc++;
      if (ov64 === 1'b1) got = 1;
    end
    n_checks++;
    if (cyc !== LAT64) begin
      n_fail++;
      $display("FAIL %s latency: got %0d want %0d", tag, cyc, LAT64);
    end
    n_checks++;
    if (r64 !== er || ex64 !== ee) begin
      n_fail++;
      $display("FAIL %s result: got %h/%b want %h/%b", tag, r64, ex64, er, ee);
    end
    or64 = 1'b1;
    @(posedge clock);
    #1 or64 = 1'b0;
    n_checks++;
    if (ov64 !== 1'b0 || ir64 !== 1'b1) begin
      n_fail++;
      $display("FAIL %s release: got ov=%b ir=%b want 0/1", tag, ov64, ir64);
    end
  endtask

  task automatic job16(input logic [15:0] v, input logic [7:0] er,
                       input logic ee, input int idx);
    int cyc;
    bit got;
    @(negedge clock);
    iv16 = 1'b1;
    v16  = v;
    @(posedge clock);
    #1 iv16 = 1'b0;
    cyc = 0;
    got = 0;
    while (!got && cyc < BOUND) begin
      @(posedge clock);
      #1;
      cyc++;
      if (ov16 === 1'b1) got = 1;
    end
    n_checks++;
    if (cyc !== LAT16) begin
      n_fail++;
      $display("FAIL rand16[%0d] latency: got %0d want %0d", idx, cyc, LAT16);
    end
    n_checks++;
    if (r16 !== er || ex16 !== ee) begin
      n_fail++;
      $display("FAIL rand16[%0d] v=%h: got %h/%b want %h/%b",
               idx, v, r16, ex16, er, ee);
    end
    or16 = 1'b1;
    @(posedge clock);
    #1 or16 = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    iv64 = 0; or64 = 0; v64 = '0;
    iv16 = 0; or16 = 0; v16 = '0;
    repeat (3) @(posedge clock);
    #1;
    n_checks++;
    if ({ir64, ov64, r64, ex64} !== {1'b1, 1'b0, 32'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset64: got ir=%b ov=%b r=%h ex=%b want 1/0/0/0",
               ir64, ov64, r64, ex64);
    end
    n_checks++;
    if ({ir16, ov16, r16, ex16} !== {1'b1, 1'b0, 8'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset16: got ir=%b ov=%b r=%h ex=%b want 1/0/0/0",
               ir16, ov16, r16, ex16);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    job64(64'd16, 32'd4, 1'b1, "v16");
    job64(64'd15, 32'd3, 1'b0, "v15");
    job64(64'd0, 32'd0, 1'b1, "v0");
    job64(64'd1, 32'd1, 1'b1, "v1");
  endtask

  task automatic test_extremes();
    job64(64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "vmax");
    job64(64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFF, 1'b1, "vsqmax");
  endtask

  task automatic test_random64();
    logic [63:0] v;
    logic [31:0] er;
    logic [31:0] rr;
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) begin
        v = {$urandom, $urandom};
      end else begin
        rr = $urandom;
        v  = {32'd0, rr} * {32'd0, rr};
      end
      er = ref_sqrt64(v);
      job64(v, er, ({32'd0, er} * {32'd0, er}) == v, "rand64");
    end
  endtask

  task automatic test_stall();
    int cyc;
    @(negedge clock);
    iv64 = 1'b1;
    v64  = 64'd100;
    @(posedge clock);
    #1 iv64 = 1'b0;
    cyc = 0;
    while (ov64 !== 1'b1 && cyc < BOUND) begin
      @(posedge clock);
      #1;
      cyc++;
    end
    n_checks++;
    if (ov64 !== 1'b1) begin
      n_fail++;
      $display("FAIL stall start: got ov=%b want 1", ov64);
    end
    iv64 = 1'b1;
    v64  = 64'd49;
    for (int i = 0; i < 50; i++) begin
      @(posedge clock);
      #1;
      n_checks++;
      if ({ov64, ir64, r64, ex64} !== {1'b1, 1'b0, 32'd10, 1'b1}) begin
        n_fail++;
        $display("FAIL stall[%0d]: got ov=%b ir=%b r=%h ex=%b want 1/0/a/1",
                 i, ov64, ir64, r64, ex64);
      end
    end
    iv64 = 1'b0;
    or64 = 1'b1;
    @(posedge clock);
    #1 or64 = 1'b0;
    n_checks++;
    if ({ov64, ir64, r64} !== {1'b0, 1'b1, 32'd10}) begin
      n_fail++;
      $display("FAIL stall release: got ov=%b ir=%b r=%h want 0/1/a",
               ov64, ir64, r64);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clock);
    iv64 = 1'b1;
    v64  = 64'd12345;
    @(posedge clock);
    #1 iv64 = 1'b0;
    repeat (99) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1;
    n_checks++;
    if (ov64 !== 1'b0 || ir64 !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset: got ov=%b ir=%b want 0/1", ov64, ir64);
    end
    reset = 1'b0;
    job64(64'd81, 32'd9, 1'b1, "after_reset");
  endtask

  task automatic test_random16();
    logic [15:0] v;
    int er;
    for (int i = 0; i < 500; i++) begin
      if (i == 0) v = 16'd0;
      else if (i == 1) v = 16'hFFFF;
      else v = 16'($urandom);
      er = ref_sqrt16(int'(v));
      job16(v, 8'(er), (er * er) == int'(v), i);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_random64();
    test_stall();
    test_reset_mid();
    test_random16();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
